dcache_miss_ctrl: RTL and testbench
===================================

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of miss and write-back event counters.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 req_i  input  1  CPU data access this cycle (MemRead OR MemWrite from MEM stage).
REQ-005 write_i  input  1  access is a store; qualifies req_i.
REQ-006 hit_i  input  1  tag match AND valid for the indexed line, from the tag compare.
REQ-007 dirty_i  input  1  indexed (victim) line is valid and dirty.
REQ-008 mem_ack_i  input  1  data memory completed current transfer; one-cycle pulse.
REQ-009 stall_o  output  1  freeze pipeline; combinational.
REQ-010 mem_enable_o  output  1  memory transfer request; registered.
REQ-011 mem_write_o  output  1  transfer is write-back of victim line; registered.
REQ-012 write_back_o  output  1  memory address from victim tag (1) or CPU tag (0); registered.
REQ-013 cache_we_o  output  1  write refilled line into data/tag SRAM, set valid, clear dirty; registered.
REQ-014 miss_cnt_o  output  CNT_W  total misses accepted.
REQ-015 wb_cnt_o  output  CNT_W  total dirty write-backs started.

Function
REQ-016 States SHALL be IDLE, MISS, WRITEBACK, READMISS, READMISSOK; encoding free.
REQ-017 IDLE: req_i=1 and hit_i=0 -> MISS; miss_cnt_o increments; otherwise remain IDLE.
REQ-018 MISS (one cycle): dirty_i=1 -> WRITEBACK, registering mem_enable_o=1, mem_write_o=1, write_back_o=1, wb_cnt_o increments; dirty_i=0 -> READMISS, registering mem_enable_o=1, mem_write_o=0, write_back_o=0.
REQ-019 WRITEBACK: hold outputs until mem_ack_i=1; then -> READMISS with mem_enable_o=1, mem_write_o=0, write_back_o=0 on next cycle (no idle gap between transfers).
REQ-020 READMISS: hold mem_enable_o=1 until mem_ack_i=1; then -> READMISSOK with mem_enable_o=0, cache_we_o=1.
REQ-021 READMISSOK (one cycle): cache_we_o returns to 0 on exit; -> IDLE unconditionally.
REQ-022 cache_we_o SHALL be high for exactly one cycle per miss.
REQ-023 stall_o = (state != IDLE) OR (state == IDLE AND req_i AND NOT hit_i).
REQ-024 Hit (read or write) in IDLE: stall_o=0, no state change, counters unchanged.
REQ-025 Once MISS entered, sequence completes regardless of req_i, write_i, hit_i changes; dirty_i sampled only in MISS.
REQ-026 mem_ack_i in IDLE, MISS, or READMISSOK SHALL be ignored.
REQ-027 Counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-028 Store miss handled identically to load miss (write-allocate); store data merge is outside this block.
REQ-029 Minimum clean-miss stall: 4 cycles with mem_ack_i arriving first cycle mem_enable_o is high (IDLE, MISS, READMISS, READMISSOK).

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, mem_enable_o=0, mem_write_o=0, write_back_o=0, cache_we_o=0, miss_cnt_o=0, wb_cnt_o=0.
REQ-031 Reset mid-transfer (any state) SHALL abort without issuing cache_we_o; pending mem_ack_i after reset ignored.
REQ-032 stall_o during reset follows REQ-023 with state IDLE.

Verification
REQ-033 Read hit: req_i=1, hit_i=1 for 3 cycles -> stall_o=0 throughout, state IDLE, miss_cnt_o=0.
REQ-034 Clean miss: req_i=1, hit_i=0, dirty_i=0, mem_ack_i 3 cycles after mem_enable_o rises -> stall_o high 6 cycles, mem_write_o=0 always, cache_we_o single pulse, miss_cnt_o=1, wb_cnt_o=0.
REQ-035 Dirty miss: dirty_i=1, ack 2 cycles into each transfer -> mem_write_o=1 and write_back_o=1 in WRITEBACK, then 0 in READMISS with mem_enable_o continuously high, miss_cnt_o=1, wb_cnt_o=1.
REQ-036 Reset in READMISS: assert rst_i one cycle, then mem_ack_i=1 -> cache_we_o never asserts, all outputs 0, state IDLE.
REQ-037 Spurious ack: mem_ack_i=1 in IDLE and in MISS -> no state skip, MISS still lasts one cycle.
REQ-038 Saturation: CNT_W=2, 5 clean misses -> miss_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/dcache_miss_ctrl_if.sv
// Bundle of CPU-side and memory-side signals for the data-cache miss controller.
// The controller connects via the slave modport; the CPU/memory side uses master.
interface dcache_miss_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             req_i;
   logic             write_i;
   logic             hit_i;
   logic             dirty_i;
   logic             mem_ack_i;
   logic             stall_o;
   logic             mem_enable_o;
   logic             mem_write_o;
   logic             write_back_o;
   logic             cache_we_o;
   logic [CNT_W-1:0] miss_cnt_o;
   logic [CNT_W-1:0] wb_cnt_o;

   modport master (
      output req_i, write_i, hit_i, dirty_i, mem_ack_i,
      input  stall_o, mem_enable_o, mem_write_o, write_back_o, cache_we_o,
      input  miss_cnt_o, wb_cnt_o
   );

   modport slave (
      input  req_i, write_i, hit_i, dirty_i, mem_ack_i,
      output stall_o, mem_enable_o, mem_write_o, write_back_o, cache_we_o,
      output miss_cnt_o, wb_cnt_o
   );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: on a miss it optionally writes back the dirty
// victim line, then refills the line from memory and pulses the cache write
// enable once. Keeps saturating counters of misses and write-backs.
module dcache_miss_ctrl #(
   parameter int CNT_W = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   dcache_miss_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   state_t           state_q, state_d;
   logic             memEnable_q, memEnable_d;
   logic             memWrite_q, memWrite_d;
   logic             writeBack_q, writeBack_d;
   logic             cacheWe_q, cacheWe_d;
   logic [CNT_W-1:0] missCnt_q, missCnt_d;
   logic [CNT_W-1:0] wbCnt_q, wbCnt_d;
   logic             missDetect;
   logic             unusedWrite;

   // Stores are write-allocate and follow the load path, so the store flag has no effect here.
   assign unusedWrite = bus.write_i;

   assign missDetect = bus.req_i & ~bus.hit_i;

   // While reset is held the controller is treated as idle, so only a fresh miss stalls.
   assign bus.stall_o = rst_i ? missDetect : ((state_q != IDLE) | missDetect);

   assign bus.mem_enable_o = memEnable_q;
   assign bus.mem_write_o  = memWrite_q;
   assign bus.write_back_o = writeBack_q;
   assign bus.cache_we_o   = cacheWe_q;
   assign bus.miss_cnt_o   = missCnt_q;
   assign bus.wb_cnt_o     = wbCnt_q;

   // Next-state and registered-output logic; memory ack only matters while a transfer is open.
   always_comb begin
      state_d     = state_q;
      memEnable_d = memEnable_q;
      memWrite_d  = memWrite_q;
      writeBack_d = writeBack_q;
      cacheWe_d   = 1'b0;
      missCnt_d   = missCnt_q;
      wbCnt_d     = wbCnt_q;
      case (state_q)
         IDLE: begin
            memEnable_d = 1'b0;
            memWrite_d  = 1'b0;
            writeBack_d = 1'b0;
            if (missDetect) begin
               state_d = MISS;
               if (missCnt_q != '1) missCnt_d = missCnt_q + CNT_W'(1);
            end
         end
         MISS: begin
            memEnable_d = 1'b1;
            if (bus.dirty_i) begin
               state_d     = WRITEBACK;
               memWrite_d  = 1'b1;
               writeBack_d = 1'b1;
               if (wbCnt_q != '1) wbCnt_d = wbCnt_q + CNT_W'(1);
            end else begin
               state_d     = READMISS;
               memWrite_d  = 1'b0;
               writeBack_d = 1'b0;
            end
         end
         WRITEBACK: begin
            if (bus.mem_ack_i) begin
               state_d     = READMISS;
               memEnable_d = 1'b1;
               memWrite_d  = 1'b0;
               writeBack_d = 1'b0;
            end
         end
         READMISS: begin
            if (bus.mem_ack_i) begin
               state_d     = READMISSOK;
               memEnable_d = 1'b0;
               cacheWe_d   = 1'b1;
            end
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            memEnable_d = 1'b0;
            memWrite_d  = 1'b0;
            writeBack_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer without a refill write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         memEnable_q <= 1'b0;
         memWrite_q  <= 1'b0;
         writeBack_q <= 1'b0;
         cacheWe_q   <= 1'b0;
         missCnt_q   <= '0;
         wbCnt_q     <= '0;
      end else begin
         state_q     <= state_d;
         memEnable_q <= memEnable_d;
         memWrite_q  <= memWrite_d;
         writeBack_q <= writeBack_d;
         cacheWe_q   <= cacheWe_d;
         missCnt_q   <= missCnt_d;
         wbCnt_q     <= wbCnt_d;
      end
   end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized bench for dcache_miss_ctrl: two instances (16-bit and 2-bit
// counters) share stimulus and are compared against a transaction-level model.
module tb_dcache_miss_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   dcache_miss_ctrl_if #(.CNT_W(16)) busBig ();
   dcache_miss_ctrl_if #(.CNT_W(2))  busSmall ();

   dcache_miss_ctrl #(.CNT_W(16)) dutBig (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (busBig)
   );

   dcache_miss_ctrl #(.CNT_W(2)) dutSmall (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (busSmall)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: a miss is a list of pending memory transfers ("W" then "R")
   // followed by one refill cycle.
   bit           req, wr, hit, dirty, ack;
   bit           busy, decidePending;
   byte          xferQ[$];
   int unsigned  expMissBig, expWbBig, expMissSmall, expWbSmall;
   bit           expEn, expWr, expWbSel, expWe;

   function automatic int unsigned satInc(input int unsigned value, input int unsigned maxVal);
      return (value >= maxVal) ? maxVal : value + 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus();
      rst   = ($urandom_range(0, 99) < 2);
      req   = ($urandom_range(0, 99) < 60);
      hit   = ($urandom_range(0, 99) < 40);
      wr    = $urandom_range(0, 1) == 1;
      dirty = $urandom_range(0, 1) == 1;
      ack   = ($urandom_range(0, 99) < 35);
      busBig.req_i       = req;   busSmall.req_i     = req;
      busBig.write_i     = wr;    busSmall.write_i   = wr;
      busBig.hit_i       = hit;   busSmall.hit_i     = hit;
      busBig.dirty_i     = dirty; busSmall.dirty_i   = dirty;
      busBig.mem_ack_i   = ack;   busSmall.mem_ack_i = ack;
   endtask

   task automatic modelReset();
      busy = 0; decidePending = 0; xferQ.delete();
      expEn = 0; expWr = 0; expWbSel = 0; expWe = 0;
      expMissBig = 0; expWbBig = 0; expMissSmall = 0; expWbSmall = 0;
   endtask

   task automatic modelStep();
      if (rst) begin
         modelReset();
         return;
      end
      expWe = 0;
      if (!busy) begin
         if (req && !hit) begin
            busy = 1;
            decidePending = 1;
            expMissBig   = satInc(expMissBig, 65535);
            expMissSmall = satInc(expMissSmall, 3);
         end
      end else if (decidePending) begin
         decidePending = 0;
         if (dirty) begin
            xferQ.push_back("W");
            expWbBig   = satInc(expWbBig, 65535);
            expWbSmall = satInc(expWbSmall, 3);
         end
         xferQ.push_back("R");
         expEn    = 1;
         expWr    = (xferQ[0] == "W");
         expWbSel = (xferQ[0] == "W");
      end else if (xferQ.size() != 0) begin
         if (ack) begin
            void'(xferQ.pop_front());
            if (xferQ.size() == 0) begin
               expEn = 0;
               expWe = 1;
            end else begin
               expWr    = 0;
               expWbSel = 0;
            end
         end
      end else begin
         busy = 0;
      end
   endtask

   task automatic checkRegistered();
      checkOutput("big.mem_enable",   busBig.mem_enable_o,   expEn);
      checkOutput("big.mem_write",    busBig.mem_write_o,    expWr);
      checkOutput("big.write_back",   busBig.write_back_o,   expWbSel);
      checkOutput("big.cache_we",     busBig.cache_we_o,     expWe);
      checkOutput("big.miss_cnt",     busBig.miss_cnt_o,     expMissBig);
      checkOutput("big.wb_cnt",       busBig.wb_cnt_o,       expWbBig);
      checkOutput("small.mem_enable", busSmall.mem_enable_o, expEn);
      checkOutput("small.mem_write",  busSmall.mem_write_o,  expWr);
      checkOutput("small.write_back", busSmall.write_back_o, expWbSel);
      checkOutput("small.cache_we",   busSmall.cache_we_o,   expWe);
      checkOutput("small.miss_cnt",   busSmall.miss_cnt_o,   expMissSmall);
      checkOutput("small.wb_cnt",     busSmall.wb_cnt_o,     expWbSmall);
   endtask

   // Main sequence: two reset cycles, then random traffic checked every cycle.
   initial begin
      bit expStall;
      checks   = 0;
      failures = 0;
      modelReset();
      rst = 1; req = 0; wr = 0; hit = 0; dirty = 0; ack = 0;
      busBig.req_i = 0;   busBig.write_i = 0;   busBig.hit_i = 0;
      busBig.dirty_i = 0; busBig.mem_ack_i = 0;
      busSmall.req_i = 0;   busSmall.write_i = 0;   busSmall.hit_i = 0;
      busSmall.dirty_i = 0; busSmall.mem_ack_i = 0;
      repeat (2) @(posedge clk);
      #1;
      checkRegistered();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         applyStimulus();
         #1;
         expStall = rst ? (req && !hit) : (busy || (req && !hit));
         checkOutput("big.stall",   busBig.stall_o,   expStall);
         checkOutput("small.stall", busSmall.stall_o, expStall);
         @(posedge clk);
         modelStep();
         #1;
         checkRegistered();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
